// File: rtl/uart_link_if.sv
// uart_link_if: the core's two byte handshakes toward the serial link
// master is the core side, slave is the uart_link side.
interface uart_link_if;
    logic [7:0] uart_in_data;
    logic       uart_in_valid;
    logic       uart_in_ready;
    logic       uart_out_valid;
    logic [7:0] uart_out_data;
    logic       uart_out_ready;
    modport master (
        output uart_in_data, uart_in_valid, uart_out_valid,
        input  uart_in_ready, uart_out_data, uart_out_ready
    );
    modport slave (
        input  uart_in_data, uart_in_valid, uart_out_valid,
        output uart_in_ready, uart_out_data, uart_out_ready
    );
endinterface

// File: rtl/uart_link.sv
// uart_link: 8N1 transmitter plus FIFO-backed 8N1 receiver answering the core's byte handshakes
// Both handshakes are guarded by arm flags so a valid lingering one cycle past ready is not served twice.
module uart_link #(
    parameter int CLK_PER_BIT = 868,
    parameter int RX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    uart_link_if.slave bus,
    output logic       txd,
    input  logic       rxd,
    output logic       rx_overrun,
    output logic       rx_frame_err
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] BIT_END = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2);
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    tx_state_t tx_state_q, tx_state_d;
    rx_state_t rx_state_q, rx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic txd_q, txd_d, in_ready_q, in_ready_d, in_arm_q, in_arm_d;
    logic rxd_s1_q, rxd_s2_q, ferr_q, ferr_d, overrun_q, overrun_d;
    logic out_ready_q, out_ready_d, out_arm_q, out_arm_d;
    logic [7:0] out_data_q, out_data_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic [7:0] fifo_mem [RX_DEPTH];
    logic tx_tick, rx_zero, rx_push, serve, full, wr_en;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_bit_d = tx_bit_q;
        tx_shift_d = tx_shift_q;
        in_ready_d = 1'b0;
        in_arm_d = bus.uart_in_valid ? in_arm_q : 1'b1;
        tx_tick = tx_cnt_q == BIT_END;
        tx_cnt_d = tx_state_q == TX_IDLE ? tx_cnt_q : tx_tick ? '0 : tx_cnt_q + CW'(1);
        case (tx_state_q)
            TX_IDLE: if (bus.uart_in_valid && in_arm_q) begin
                tx_shift_d = bus.uart_in_data;
                in_ready_d = 1'b1;
                in_arm_d = 1'b0;
                tx_cnt_d = '0;
                tx_state_d = TX_START;
            end
            TX_START: if (tx_tick) begin
                tx_bit_d = '0;
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_tick) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            end
            default: if (tx_tick) tx_state_d = TX_IDLE;
        endcase
        // txd trails the state by one cycle, so the start bit begins the cycle after ready
        txd_d = tx_state_q == TX_START ? 1'b0 : tx_state_q == TX_DATA ? tx_shift_q[0] : 1'b1;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_bit_d = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push = 1'b0;
        ferr_d = ferr_q;
        rx_zero = rx_cnt_q == '0;
        rx_cnt_d = rx_zero ? BIT_END : rx_cnt_q - CW'(1);
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = HALF;
                if (!rxd_s2_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_zero) begin
                rx_bit_d = '0;
                rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_zero) begin
                rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_zero) begin
                rx_push = rxd_s2_q;
                ferr_d = ferr_q | !rxd_s2_q;
                rx_state_d = rxd_s2_q ? RX_IDLE : RX_WAIT_HIGH;
            end
            default: if (rxd_s2_q) rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        serve = bus.uart_out_valid && out_arm_q && count_q != '0;
        full = count_q == (AW+1)'(RX_DEPTH);
        // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
        wr_en = rx_push && (!full || serve);
        overrun_d = overrun_q | (rx_push && full && !serve);
        out_ready_d = serve;
        out_data_d = serve ? fifo_mem[rd_ptr_q] : out_data_q;
        out_arm_d = serve ? 1'b0 : bus.uart_out_valid ? out_arm_q : 1'b1;
        rd_ptr_d = rd_ptr_q + AW'(serve);
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(serve);
    end

    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr_q] <= rx_shift_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_shift_q <= '0;
            txd_q <= 1'b1;
            in_ready_q <= 1'b0;
            in_arm_q <= 1'b1;
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_shift_q <= '0;
            ferr_q <= 1'b0;
            overrun_q <= 1'b0;
            out_ready_q <= 1'b0;
            out_arm_q <= 1'b1;
            out_data_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q <= tx_cnt_d;
            tx_bit_q <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q <= txd_d;
            in_ready_q <= in_ready_d;
            in_arm_q <= in_arm_d;
            rxd_s1_q <= rxd;
            rxd_s2_q <= rxd_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q <= rx_cnt_d;
            rx_bit_q <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            ferr_q <= ferr_d;
            overrun_q <= overrun_d;
            out_ready_q <= out_ready_d;
            out_arm_q <= out_arm_d;
            out_data_q <= out_data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end

    assign txd = txd_q;
    assign bus.uart_in_ready = in_ready_q;
    assign bus.uart_out_ready = out_ready_q;
    assign bus.uart_out_data = out_data_q;
    assign rx_overrun = overrun_q;
    assign rx_frame_err = ferr_q;
endmodule
